mem_access_arbiter: RTL and testbench



---
 rtl/mem_access_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// LC-3 SRAM access sequencer: shares one SRAM port between two requesters
// (port 0 = CPU control unit, port 1 = debug/program loader) using round-robin.
//
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN  request level, write flag, address, write data (N=0,1)
//   doneN               one-cycle completion pulse
//   rdataN              last read data returned to port N
//   Mem_OE/Mem_WE       SRAM enables (never both high)
//   Mem_ADDR/Mem_WDATA  SRAM address and write data
//   Mem_RDATA           SRAM read data
//   busy                high while an access or its release cycle is in flight
//   owner               port that won the most recent grant
module mem_access_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic [DATA_W-1:0] Mem_WDATA,
  input  logic [DATA_W-1:0] Mem_RDATA,
  output logic              busy,
  output logic              owner
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RELEASE
  } state_e;

  state_e state_q, state_d;

  logic [3:0]        cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              we_l_q, we_l_d;
  logic              oe_q, oe_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              busy_q, busy_d;
  logic              owner_q, owner_d;

  logic              any_req;
  logic              sel;
  logic              we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  // On a tie the port that did not win last time gets the grant.
  assign any_req   = req0 | req1;
  assign sel       = (req0 & req1) ? ~last_q : req1;
  assign we_sel    = sel ? we1 : we0;
  assign addr_sel  = sel ? addr1 : addr0;
  assign wdata_sel = sel ? wdata1 : wdata0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    we_l_d   = we_l_q;
    oe_d     = oe_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    busy_d   = busy_q;
    owner_d  = owner_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          owner_d = sel;
          last_d  = sel;
          we_l_d  = we_sel;
          addr_d  = addr_sel;
          wdata_d = wdata_sel;
          cnt_d   = CNT_INIT;
          oe_d    = ~we_sel;
          wr_d    = we_sel;
          busy_d  = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RELEASE;
          oe_d    = 1'b0;
          wr_d    = 1'b0;
          // Sample read data on the last edge OE is still high.
          if (!we_l_q) begin
            if (owner_q) rdata1_d = Mem_RDATA;
            else         rdata0_d = Mem_RDATA;
          end
          if (owner_q) done1_d = 1'b1;
          else         done0_d = 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        oe_d    = 1'b0;
        wr_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      last_q   <= 1'b1;
      we_l_q   <= 1'b0;
      oe_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
      owner_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      we_l_q   <= we_l_d;
      oe_q     <= oe_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
      owner_q  <= owner_d;
    end
  end

  assign Mem_OE    = oe_q;
  assign Mem_WE    = wr_q;
  assign Mem_ADDR  = addr_q;
  assign Mem_WDATA = wdata_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed scenarios plus random traffic
// checked against a transaction-timeline model (cycles elapsed since grant).
module tb_mem_access_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int W  = 3;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic          Reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1, rd_in;
  logic          done0, done1, oe, wr, busy, owner;
  logic [DW-1:0] rdata0, rdata1, mwd;
  logic [AW-1:0] maddr;

  logic          b_req0, b_we0, b_req1, b_we1;
  logic [AW-1:0] b_addr0, b_addr1;
  logic [DW-1:0] b_wd0, b_wd1, b_rd;
  logic          b_done0, b_done1, b_oe, b_wr, b_busy, b_owner;
  logic [DW-1:0] b_rdata0, b_rdata1, b_mwd;
  logic [AW-1:0] b_maddr;

  mem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .done0(done0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .done1(done1), .rdata1(rdata1),
    .Mem_OE(oe), .Mem_WE(wr), .Mem_ADDR(maddr), .Mem_WDATA(mwd),
    .Mem_RDATA(rd_in), .busy(busy), .owner(owner)
  );

  mem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) u_dut1 (
    .Clk(Clk), .Reset(Reset),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wd0),
    .done0(b_done0), .rdata0(b_rdata0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wd1),
    .done1(b_done1), .rdata1(b_rdata1),
    .Mem_OE(b_oe), .Mem_WE(b_wr), .Mem_ADDR(b_maddr), .Mem_WDATA(b_mwd),
    .Mem_RDATA(b_rd), .busy(b_busy), .owner(b_owner)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: an access is a timeline. Cycle g after the grant edge:
  // g=1..W enables up, g=W+1 done pulse, g=W+2 free again.
  bit            m_act;
  int            m_g;
  bit            m_own, m_last, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] m_rd [2];

  task automatic model_edge();
    bit s;
    if (Reset) begin
      m_act = 0; m_g = 0; m_own = 0; m_last = 1; m_we = 0;
      m_addr = '0; m_wd = '0; m_rd[0] = '0; m_rd[1] = '0;
      return;
    end
    if (m_act) begin
      if (m_g == W && !m_we) m_rd[m_own] = rd_in;
      m_g++;
      if (m_g == W + 2) m_act = 0;
    end else if (req0 || req1) begin
      s = (req0 && req1) ? ~m_last : req1;
      m_own = s; m_last = s;
      m_we   = s ? we1 : we0;
      m_addr = s ? addr1 : addr0;
      m_wd   = s ? wdata1 : wdata0;
      m_act = 1; m_g = 1;
    end
  endtask

  task automatic check_all();
    bit en, dn;
    en = m_act && m_g <= W;
    dn = m_act && m_g == W + 1;
    chk("oe", 32'(oe), 32'(en && !m_we));
    chk("we", 32'(wr), 32'(en && m_we));
    chk("done0", 32'(done0), 32'(dn && !m_own));
    chk("done1", 32'(done1), 32'(dn && m_own));
    chk("busy", 32'(busy), 32'(m_act));
    chk("owner", 32'(owner), 32'(m_own));
    chk("addr", 32'(maddr), 32'(m_addr));
    chk("wdata", 32'(mwd), 32'(m_wd));
    chk("rdata0", 32'(rdata0), 32'(m_rd[0]));
    chk("rdata1", 32'(rdata1), 32'(m_rd[1]));
    chk("oe_we_excl", 32'(oe & wr), 32'd0);
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
  endtask

  int oe_n, done_at, n;
  bit own_seq [4];

  initial begin
    Reset = 1; req0 = 0; we0 = 0; req1 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    rd_in = 16'hBEEF;
    b_req0 = 0; b_we0 = 0; b_req1 = 0; b_we1 = 0;
    b_addr0 = '0; b_addr1 = '0; b_wd0 = '0; b_wd1 = '0;
    b_rd = 16'hA5A5;
    step(); step();
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    Reset = 0;

    // Port 0 read
    req0 = 1; we0 = 0; addr0 = 20'h00040;
    step();
    req0 = 0;
    oe_n = 0; done_at = 0;
    for (int k = 1; k <= W + 2; k++) begin
      if (oe && maddr == 20'h00040) oe_n++;
      if (done0) done_at = k;
      step();
    end
    chk("rd_oe_cycles", 32'(oe_n), 32'd3);
    chk("rd_done_at", 32'(done_at), 32'd4);
    chk("rd_rdata0", 32'(rdata0), 32'hBEEF);

    // Port 1 write
    req1 = 1; we1 = 1; addr1 = 20'h00012; wdata1 = 16'h1234;
    step();
    req1 = 0;
    oe_n = 0; done_at = 0;
    for (int k = 1; k <= W + 2; k++) begin
      if (wr && maddr == 20'h00012 && mwd == 16'h1234) oe_n++;
      if (done1) done_at = k;
      step();
    end
    chk("wr_we_cycles", 32'(oe_n), 32'd3);
    chk("wr_done_at", 32'(done_at), 32'd4);
    chk("wr_rdata1", 32'(rdata1), 32'd0);

    // Contention from reset
    Reset = 1; step(); Reset = 0;
    req0 = 1; we0 = 0; req1 = 1; we1 = 0;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      step();
      if (done0 || done1) begin
        own_seq[n] = done1;
        n++;
      end
    end
    req0 = 0; req1 = 0;
    chk("cont_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("cont_owner", 32'(own_seq[i]), 32'(i % 2));
    step(); step();

    // Input changes mid-access are ignored
    req0 = 1; we0 = 0; addr0 = 20'h00040;
    step();
    req0 = 0;
    step();
    addr0 = 20'h00099;
    for (int k = 2; k <= W + 1; k++) begin
      step();
      chk("stable_addr", 32'(maddr), 32'h00040);
    end
    step();

    // Reset aborts a read in its 2nd access cycle
    rd_in = 16'h5555;
    req0 = 1; we0 = 0; addr0 = 20'h00040;
    step();
    req0 = 0;
    step();
    Reset = 1;
    step();
    Reset = 0;
    chk("abort_oe", 32'(oe), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rdata0", 32'(rdata0), 32'd0);
    for (int k = 0; k < 4; k++) step();
    req0 = 1;
    step();
    req0 = 0;
    for (int k = 0; k < W + 2; k++) step();
    chk("after_abort_rd", 32'(rdata0), 32'h5555);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      Reset  = ($urandom_range(0, 99) == 0);
      req0   = ($urandom_range(0, 2) != 0);
      req1   = ($urandom_range(0, 2) != 0);
      we0    = 1'($urandom);
      we1    = 1'($urandom);
      addr0  = AW'($urandom);
      addr1  = AW'($urandom);
      wdata0 = DW'($urandom);
      wdata1 = DW'($urandom);
      rd_in  = DW'($urandom);
      step();
    end
    Reset = 0; req0 = 0; req1 = 0;
    for (int k = 0; k < W + 3; k++) step();

    // WAIT_CYCLES=1 instance
    b_req0 = 1; b_we0 = 0; b_addr0 = 20'h00321;
    step();
    b_req0 = 0;
    chk("w1_oe_c1", 32'(b_oe), 32'd1);
    chk("w1_addr", 32'(b_maddr), 32'h00321);
    chk("w1_done_c1", 32'(b_done0), 32'd0);
    step();
    chk("w1_oe_c2", 32'(b_oe), 32'd0);
    chk("w1_done_c2", 32'(b_done0), 32'd1);
    chk("w1_rdata0", 32'(b_rdata0), 32'hA5A5);
    step();
    chk("w1_done_c3", 32'(b_done0), 32'd0);
    chk("w1_busy_c3", 32'(b_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
